// File: rtl/miter_pkg.sv
// Shared definitions for the miter vector sequencer.
//   state_e      : sequencer FSM states (3-bit encoding)
//   DEF_NUM_IN   : default miter primary-input count (vector width)
//   DEF_NUM_OUT  : default number of outputs compared per circuit copy
//   sweep_len(n) : number of vectors in an exhaustive sweep of n inputs
package miter_pkg;

  localparam int DEF_NUM_IN  = 3;
  localparam int DEF_NUM_OUT = 2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_APPLY = 3'd1,
    ST_WAIT  = 3'd2,
    ST_CHECK = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  function automatic int unsigned sweep_len(input int unsigned n);
    return 32'd1 << n;
  endfunction

endpackage

// File: rtl/miter_vector_sequencer_if.sv
// Bus between the ECO test harness / combinational miter and the sequencer.
//   start, abort       harness -> sequencer control
//   f_out, g_out       miter copies -> sequencer ({y1,y2} each)
//   in_vec             sequencer -> both miter copies (shared stimulus)
//   busy, done, pass, aborted, cex_vec, cex_diff, fail_cnt
//                      sequencer -> harness status and result
// The sequencer connects through the slave modport; the harness side
// (stimulus, miter datapath) uses the master modport.
interface miter_vector_sequencer_if
  import miter_pkg::*;
#(
  parameter int NUM_IN  = DEF_NUM_IN,
  parameter int NUM_OUT = DEF_NUM_OUT
);

  logic                start;
  logic                abort;
  logic [NUM_OUT-1:0]  f_out;
  logic [NUM_OUT-1:0]  g_out;
  logic [NUM_IN-1:0]   in_vec;
  logic                busy;
  logic                done;
  logic                pass;
  logic                aborted;
  logic [NUM_IN-1:0]   cex_vec;
  logic [NUM_OUT-1:0]  cex_diff;
  logic [NUM_IN:0]     fail_cnt;

  modport master (
    output start, abort, f_out, g_out,
    input  in_vec, busy, done, pass, aborted, cex_vec, cex_diff, fail_cnt
  );

  modport slave (
    input  start, abort, f_out, g_out,
    output in_vec, busy, done, pass, aborted, cex_vec, cex_diff, fail_cnt
  );

endinterface

// File: rtl/miter_settle_timer.sv
// Loadable down-counter that times the WAIT phase of each vector.
//   clk     in  rising-edge clock
//   rst     in  synchronous, active-high reset
//   load    in  restart the settle interval (asserted in APPLY)
//   expired out high once SETTLE cycles have elapsed since the load edge
// Loading SETTLE-1 makes expired rise in the SETTLE-th cycle after load,
// so the WAIT state lasts exactly SETTLE cycles.
module miter_settle_timer #(
  parameter int SETTLE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic expired
);

  localparam int CNT_W = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(SETTLE - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = RELOAD;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == '0);

endmodule

// File: rtl/miter_vector_sequencer.sv
// Exhaustive stimulus sequencer for an ECO miter (golden copy F, patched
// copy G). Walks every input vector, compares the copies' outputs and
// reports the first counterexample, or pass after the full sweep.
//   clk, rst   rising-edge clock, synchronous active-high reset
//   bus        slave side of miter_vector_sequencer_if:
//              start/abort control, f_out/g_out compared outputs,
//              in_vec shared stimulus, busy/done/pass/aborted status,
//              cex_vec/cex_diff first failure, fail_cnt failure count
// Each vector costs SETTLE+2 cycles: APPLY, SETTLE x WAIT, CHECK.
module miter_vector_sequencer
  import miter_pkg::*;
#(
  parameter int NUM_IN       = DEF_NUM_IN,
  parameter int NUM_OUT      = DEF_NUM_OUT,
  parameter int SETTLE       = 1,
  parameter int STOP_ON_FAIL = 1
) (
  input logic                     clk,
  input logic                     rst,
  miter_vector_sequencer_if.slave bus
);

  localparam int CNT_W = NUM_IN + 1;
  // Counter is one bit wider than the vector so the last vector is
  // compared explicitly instead of relying on a wrap to zero.
  localparam logic [CNT_W-1:0] LAST_VEC = CNT_W'(sweep_len(NUM_IN) - 1);
  localparam logic [CNT_W-1:0] FAIL_MAX = CNT_W'(sweep_len(NUM_IN));

  state_e              state_q,    state_d;
  logic [CNT_W-1:0]    vec_cnt_q,  vec_cnt_d;
  logic [NUM_IN-1:0]   in_vec_q,   in_vec_d;
  logic [NUM_IN-1:0]   cex_vec_q,  cex_vec_d;
  logic [NUM_OUT-1:0]  cex_diff_q, cex_diff_d;
  logic [CNT_W-1:0]    fail_cnt_q, fail_cnt_d;
  logic                busy_q,     busy_d;
  logic                done_q,     done_d;
  logic                pass_q,     pass_d;
  logic                aborted_q,  aborted_d;

  logic                settle_load;
  logic                settle_expired;
  logic                finish;
  logic [NUM_OUT-1:0]  diff;
  logic                mismatch;

  generate
    if (SETTLE > 0) begin : g_settle
      miter_settle_timer #(
        .SETTLE (SETTLE)
      ) u_settle (
        .clk     (clk),
        .rst     (rst),
        .load    (settle_load),
        .expired (settle_expired)
      );
    end else begin : g_no_settle
      assign settle_expired = 1'b1;
    end
  endgenerate

  // The miter datapath is combinational in in_vec; its outputs are only
  // meaningful (and only used) in CHECK.
  assign diff     = bus.f_out ^ bus.g_out;
  assign mismatch = |diff;

  // NOTE: every signal assigned here gets a default first, so no path
  // through the case leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    vec_cnt_d   = vec_cnt_q;
    in_vec_d    = in_vec_q;
    cex_vec_d   = cex_vec_q;
    cex_diff_d  = cex_diff_q;
    fail_cnt_d  = fail_cnt_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    pass_d      = pass_q;
    aborted_d   = aborted_q;
    settle_load = 1'b0;
    finish      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d    = ST_APPLY;
          vec_cnt_d  = '0;
          cex_vec_d  = '0;
          cex_diff_d = '0;
          fail_cnt_d = '0;
          pass_d     = 1'b0;
          aborted_d  = 1'b0;
          busy_d     = 1'b1;
        end
      end

      ST_APPLY: begin
        if (bus.abort) begin
          finish = 1'b1;
        end else begin
          in_vec_d    = vec_cnt_q[NUM_IN-1:0];
          settle_load = 1'b1;
          state_d     = (SETTLE > 0) ? ST_WAIT : ST_CHECK;
        end
      end

      ST_WAIT: begin
        if (bus.abort) begin
          finish = 1'b1;
        end else if (settle_expired) begin
          state_d = ST_CHECK;
        end
      end

      ST_CHECK: begin
        // The compare is recorded even when abort ends the sweep here.
        if (mismatch) begin
          if (fail_cnt_q != FAIL_MAX) begin
            fail_cnt_d = fail_cnt_q + 1'b1;
          end
          if (fail_cnt_q == '0) begin
            cex_vec_d  = in_vec_q;
            cex_diff_d = diff;
          end
        end
        if (bus.abort
            || ((STOP_ON_FAIL != 0) && mismatch)
            || (vec_cnt_q == LAST_VEC)) begin
          finish = 1'b1;
        end else begin
          vec_cnt_d = vec_cnt_q + 1'b1;
          state_d   = ST_APPLY;
        end
      end

      // DONE always returns to IDLE; a late abort has nothing left to end.
      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (finish) begin
      state_d   = ST_DONE;
      busy_d    = 1'b0;
      done_d    = 1'b1;
      aborted_d = bus.abort;
      pass_d    = !bus.abort && (fail_cnt_d == '0);
    end
  end

  // NOTE: state is updated with non-blocking assignments so every flop
  // samples the pre-edge value of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      vec_cnt_q  <= '0;
      in_vec_q   <= '0;
      cex_vec_q  <= '0;
      cex_diff_q <= '0;
      fail_cnt_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      aborted_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      vec_cnt_q  <= vec_cnt_d;
      in_vec_q   <= in_vec_d;
      cex_vec_q  <= cex_vec_d;
      cex_diff_q <= cex_diff_d;
      fail_cnt_q <= fail_cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      aborted_q  <= aborted_d;
    end
  end

  assign bus.in_vec   = in_vec_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.pass     = pass_q;
  assign bus.aborted  = aborted_q;
  assign bus.cex_vec  = cex_vec_q;
  assign bus.cex_diff = cex_diff_q;
  assign bus.fail_cnt = fail_cnt_q;

endmodule

// File: tb/tb_miter_vector_sequencer.sv
// Scoreboard bench for miter_vector_sequencer.
// Three builds share clk/rst:
//   DUT 0: SETTLE=1, STOP_ON_FAIL=1   DUT 1: SETTLE=1, STOP_ON_FAIL=0
//   DUT 2: SETTLE=0, STOP_ON_FAIL=1
// Stimulus pushes the expected result of each sweep into sb_q; the monitor
// pops and compares whenever a DUT pulses done. Latency is counted in
// cycles after the start-accepting edge: the cycle right after that edge
// is cycle 1.
module tb_miter_vector_sequencer;

  typedef struct {
    int         id;
    logic       pass;
    logic       aborted;
    logic [2:0] cex_vec;
    logic [1:0] cex_diff;
    logic [3:0] fail_cnt;
    int         lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  int n_total = 0;
  int n_pass  = 0;

  exp_t sb_q[$];
  int   start_cyc [3];
  int   done_cnt  [3];
  int   done_base [3];
  int   mode      [3];

  logic       start_r   [3];
  logic       abort_r   [3];
  logic       obs_done  [3];
  logic       obs_busy  [3];
  logic       obs_pass  [3];
  logic       obs_abt   [3];
  logic [2:0] obs_vec   [3];
  logic [2:0] obs_cex   [3];
  logic [1:0] obs_diff  [3];
  logic [3:0] obs_fcnt  [3];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Golden function: y1 = a&b | c, y2 = a^b^c, with in_vec = {a,b,c}.
  function automatic logic [1:0] f_model(input logic [2:0] v);
    return {(v[2] & v[1]) | v[0], v[2] ^ v[1] ^ v[0]};
  endfunction

  // Bits of G that differ from F: mode 1 flips y2 at 101,
  // mode 2 flips y1 at 010 and both outputs at 110.
  function automatic logic [1:0] g_flip(input int m, input logic [2:0] v);
    case (m)
      1:       return (v == 3'b101) ? 2'b01 : 2'b00;
      2:       return (v == 3'b010) ? 2'b10 : ((v == 3'b110) ? 2'b11 : 2'b00);
      default: return 2'b00;
    endcase
  endfunction

  miter_vector_sequencer_if #(.NUM_IN(3), .NUM_OUT(2)) bus_if [3] ();

  for (genvar g = 0; g < 3; g++) begin : g_conn
    assign bus_if[g].start = start_r[g];
    assign bus_if[g].abort = abort_r[g];
    assign bus_if[g].f_out = f_model(bus_if[g].in_vec);
    assign bus_if[g].g_out = f_model(bus_if[g].in_vec) ^ g_flip(mode[g], bus_if[g].in_vec);
    assign obs_done[g] = bus_if[g].done;
    assign obs_busy[g] = bus_if[g].busy;
    assign obs_pass[g] = bus_if[g].pass;
    assign obs_abt[g]  = bus_if[g].aborted;
    assign obs_vec[g]  = bus_if[g].in_vec;
    assign obs_cex[g]  = bus_if[g].cex_vec;
    assign obs_diff[g] = bus_if[g].cex_diff;
    assign obs_fcnt[g] = bus_if[g].fail_cnt;
  end

  miter_vector_sequencer #(.NUM_IN(3), .NUM_OUT(2), .SETTLE(1), .STOP_ON_FAIL(1))
    u_dut0 (.clk(clk), .rst(rst), .bus(bus_if[0]));
  miter_vector_sequencer #(.NUM_IN(3), .NUM_OUT(2), .SETTLE(1), .STOP_ON_FAIL(0))
    u_dut1 (.clk(clk), .rst(rst), .bus(bus_if[1]));
  miter_vector_sequencer #(.NUM_IN(3), .NUM_OUT(2), .SETTLE(0), .STOP_ON_FAIL(1))
    u_dut2 (.clk(clk), .rst(rst), .bus(bus_if[2]));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] obs_all(input int k);
    return {obs_busy[k], obs_done[k], obs_pass[k], obs_abt[k],
            obs_vec[k], obs_cex[k], obs_diff[k], obs_fcnt[k]};
  endfunction

  // Monitor: one scoreboard entry is consumed per done pulse.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (obs_done[k] === 1'b1) begin
        exp_t e;
        done_cnt[k]++;
        check($sformatf("dut%0d_done_expected", k), 32'(sb_q.size() != 0), 32'd1);
        if (sb_q.size() != 0) begin
          e = sb_q.pop_front();
          check($sformatf("dut%0d_sb_id", k),    32'(k),                32'(e.id));
          check($sformatf("dut%0d_pass", k),     32'(obs_pass[k]),      32'(e.pass));
          check($sformatf("dut%0d_aborted", k),  32'(obs_abt[k]),       32'(e.aborted));
          check($sformatf("dut%0d_cex_vec", k),  32'(obs_cex[k]),       32'(e.cex_vec));
          check($sformatf("dut%0d_cex_diff", k), 32'(obs_diff[k]),      32'(e.cex_diff));
          check($sformatf("dut%0d_fail_cnt", k), 32'(obs_fcnt[k]),      32'(e.fail_cnt));
          check($sformatf("dut%0d_latency", k),  32'(cyc - start_cyc[k]), 32'(e.lat));
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic push_exp(input int id, input logic p, input logic ab, input logic [2:0] cv,
                          input logic [1:0] cd, input logic [3:0] fc, input int lat);
    exp_t e;
    e.id = id; e.pass = p; e.aborted = ab; e.cex_vec = cv;
    e.cex_diff = cd; e.fail_cnt = fc; e.lat = lat;
    sb_q.push_back(e);
  endtask

  task automatic do_start(input int k);
    done_base[k] = done_cnt[k];
    start_cyc[k] = cyc;
    start_r[k]   = 1'b1;
    tick();
    start_r[k]   = 1'b0;
  endtask

  task automatic wait_rel(input int k, input int n);
    for (int i = 0; i < 200 && (cyc - start_cyc[k]) < n; i++) tick();
  endtask

  task automatic wait_done(input int k, input int budget);
    for (int i = 0; i < budget && done_cnt[k] == done_base[k]; i++) tick();
    check($sformatf("dut%0d_done_seen", k), 32'(done_cnt[k] != done_base[k]), 32'd1);
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      start_r[k] = 1'b0; abort_r[k] = 1'b0; mode[k] = 0;
      done_cnt[k] = 0; done_base[k] = 0; start_cyc[k] = 0;
    end
    repeat (3) tick();
    rst = 1'b0;
    tick();
    for (int k = 0; k < 3; k++) check($sformatf("dut%0d_reset_outputs", k), 32'(obs_all(k)), 32'd0);

    // 1: identical copies, full pass, vectors applied 0..7 in order.
    mode[0] = 0;
    push_exp(0, 1'b1, 1'b0, 3'd0, 2'b00, 4'd0, 25);
    do_start(0);
    check("t1_busy_after_start", 32'(obs_busy[0]), 32'd1);
    for (int v = 0; v < 8; v++) begin
      wait_rel(0, 3 * v + 2);
      check($sformatf("t1_in_vec_%0d", v), 32'(obs_vec[0]), 32'(v));
    end
    wait_done(0, 40);
    tick();
    check("t1_idle_busy", 32'(obs_busy[0]), 32'd0);
    check("t1_idle_done", 32'(obs_done[0]), 32'd0);

    // 2: single mismatch at 101 on y2, stop at first failure.
    mode[0] = 1;
    push_exp(0, 1'b0, 1'b0, 3'b101, 2'b01, 4'd1, 19);
    do_start(0);
    wait_done(0, 40);
    check("t2_in_vec_held", 32'(obs_vec[0]), 32'd5);
    tick();

    // 3: mismatches at 010 and 110, full sweep, first cex kept.
    mode[1] = 2;
    push_exp(1, 1'b0, 1'b0, 3'b010, 2'b10, 4'd2, 25);
    do_start(1);
    wait_done(1, 40);
    tick();

    // 4: abort during WAIT of vector 4.
    mode[0] = 0;
    push_exp(0, 1'b0, 1'b1, 3'd0, 2'b00, 4'd0, 15);
    do_start(0);
    wait_rel(0, 14);
    check("t4_in_vec_at_abort", 32'(obs_vec[0]), 32'd4);
    abort_r[0] = 1'b1;
    tick();
    abort_r[0] = 1'b0;
    wait_done(0, 5);
    tick();
    check("t4_idle_busy", 32'(obs_busy[0]), 32'd0);
    check("t4_idle_done", 32'(obs_done[0]), 32'd0);

    // 5: reset during CHECK of failing vector 101, then a clean sweep.
    mode[0] = 1;
    do_start(0);
    wait_rel(0, 18);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5_outputs_after_rst", 32'(obs_all(0)), 32'd0);
    mode[0] = 0;
    push_exp(0, 1'b1, 1'b0, 3'd0, 2'b00, 4'd0, 25);
    do_start(0);
    wait_rel(0, 2);
    check("t5_restart_vec0", 32'(obs_vec[0]), 32'd0);
    wait_rel(0, 5);
    check("t5_restart_vec1", 32'(obs_vec[0]), 32'd1);
    wait_done(0, 40);
    tick();

    // 6: SETTLE=0 build, start pulsed repeatedly while busy.
    mode[2] = 0;
    push_exp(2, 1'b1, 1'b0, 3'd0, 2'b00, 4'd0, 17);
    do_start(2);
    for (int r = 1; r <= 16; r++) begin
      wait_rel(2, r);
      if (r >= 2) check($sformatf("t6_in_vec_r%0d", r), 32'(obs_vec[2]), 32'((r - 2) / 2));
      start_r[2] = ((r % 2) == 1) && (r < 15);
    end
    start_r[2] = 1'b0;
    wait_done(2, 10);
    repeat (4) tick();
    check("t6_idle_busy", 32'(obs_busy[2]), 32'd0);
    check("t6_single_done", 32'(done_cnt[2] - done_base[2]), 32'd1);

    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
